// File: rtl/transmit_engine_pkg.sv
// Shared UART definitions (frame geometry, format/parity encodings), also used by the receive engine.
// Pure constants and a combinational frame-tail helper: no latency, no flow control.
package transmit_engine_pkg;

  localparam int UART_BAUD_W     = 19;
  localparam int UART_FRAME_BITS = 11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame format selected by {EIGHT, PEN}
  typedef enum logic [1:0] {
    FMT_7N = 2'b00,
    FMT_7P = 2'b01,
    FMT_8N = 2'b10,
    FMT_8P = 2'b11
  } frame_fmt_e;

  // Returns {b10, b9, b8}: the bit times that follow the first seven data bits.
  function automatic logic [2:0] frame_tail(input logic eight, input logic pen,
                                            input logic ohel, input logic [7:0] d);
    logic [2:0] tail;
    logic       par7;
    logic       par8;
    par7 = (ohel == PAR_ODD) ? ~^d[6:0] : ^d[6:0];
    par8 = (ohel == PAR_ODD) ? ~^d      : ^d;
    tail = 3'b111;
    case (frame_fmt_e'({eight, pen}))
      FMT_7N:  tail = 3'b111;
      FMT_7P:  tail = {2'b11, par7};
      FMT_8N:  tail = {2'b11, d[7]};
      FMT_8P:  tail = {1'b1, par8, d[7]};
      default: tail = 3'b111;
    endcase
    return tail;
  endfunction

endpackage

// File: rtl/transmit_engine_if.sv
// Host-side bus of the UART transmit engine: link config, LOAD strobe with byte, serial TX and TX_RDY.
// Wiring only: no latency; the host must hold LOAD off (or expect it ignored) while TX_RDY is low.
interface transmit_engine_if #(parameter int BAUD_W = transmit_engine_pkg::UART_BAUD_W);

  logic [BAUD_W-1:0] BAUD_K;
  logic              EIGHT;
  logic              PEN;
  logic              OHEL;
  logic              LOAD;
  logic [7:0]        OUT_PORT;
  logic              TX;
  logic              TX_RDY;

  modport master (
    output BAUD_K, EIGHT, PEN, OHEL, LOAD, OUT_PORT,
    input  TX, TX_RDY
  );

  modport slave (
    input  BAUD_K, EIGHT, PEN, OHEL, LOAD, OUT_PORT,
    output TX, TX_RDY
  );

endinterface

// File: rtl/transmit_engine_tx_bit_timer.sv
// Bit-time counter: counts 0..baud_k while doit, pulses btu combinationally on the terminal count.
// No backpressure; held at zero whenever doit is low so every frame starts on a full bit time.
module tx_bit_timer #(
  parameter int BAUD_W = transmit_engine_pkg::UART_BAUD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              doit,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              btu
);

  logic [BAUD_W-1:0] count;

  assign btu = doit && (count == baud_k);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!doit || btu) begin
      count <= '0;
    end else begin
      count <= count + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/transmit_engine.sv
// UART transmit engine: LOAD accepted while TX_RDY, TX falls one clock later, frame is 11 bit times LSB-first.
// TX_RDY stays low for 11*(BAUD_K+1)+2 clocks per frame; LOAD while busy is dropped.
module transmit_engine
  import transmit_engine_pkg::*;
#(
  parameter int BAUD_W     = UART_BAUD_W,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic              clk,
  input  logic              reset,
  transmit_engine_if.slave  bus
);

  logic [FRAME_BITS-1:0] sr;
  logic [7:0]            ldata;
  logic [3:0]            bit_cnt;
  logic                  loadd1;
  logic                  doit;
  logic                  tx_rdy;
  logic                  btu;
  logic                  done;
  logic [2:0]            tail;

  tx_bit_timer #(.BAUD_W(BAUD_W)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .doit   (doit),
    .baud_k (bus.BAUD_K),
    .btu    (btu)
  );

  // Format is taken from the live config only in the LOADD1 cycle.
  assign tail = frame_tail(bus.EIGHT, bus.PEN, bus.OHEL, ldata);
  assign done = (bit_cnt == 4'(FRAME_BITS));

  // The shift register LSB is the line itself, so TX is registered with no extra flop.
  assign bus.TX     = sr[0];
  assign bus.TX_RDY = tx_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '1;
      ldata   <= '0;
      bit_cnt <= '0;
      loadd1  <= 1'b0;
      doit    <= 1'b0;
      tx_rdy  <= 1'b1;
    end else begin
      loadd1 <= 1'b0;
      if (bus.LOAD && tx_rdy) begin
        ldata  <= bus.OUT_PORT;
        tx_rdy <= 1'b0;
        loadd1 <= 1'b1;
      end

      if (loadd1) begin
        sr   <= FRAME_BITS'({tail, ldata[6:0], 1'b0});
        doit <= 1'b1;
      end else if (doit) begin
        if (done) begin
          doit    <= 1'b0;
          bit_cnt <= '0;
          tx_rdy  <= 1'b1;
        end else if (btu) begin
          sr      <= {1'b1, sr[FRAME_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_transmit_engine.sv
// Directed, table-driven bench for transmit_engine: frame bit patterns, TX_RDY timing,
// ignored LOADs, mid-frame config changes and asynchronous reset mid-frame.
module tb_transmit_engine;

  logic clk;
  logic reset;

  transmit_engine_if #(.BAUD_W(19)) bus();

  transmit_engine #(.BAUD_W(19), .FRAME_BITS(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          baud_k;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [7:0]  data;
    logic [10:0] exp_bits;   // bit i = line level during bit time i
    bit          busy_load;
    bit          done_load;
    bit          flip_cfg;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.TX_RDY && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_rdy", int'(bus.TX_RDY), 1);
  endtask

  task automatic send(input vec_t v);
    wait_rdy();
    bus.BAUD_K   = 19'(v.baud_k);
    bus.EIGHT    = v.eight;
    bus.PEN      = v.pen;
    bus.OHEL     = v.ohel;
    bus.OUT_PORT = v.data;
    bus.LOAD     = 1'b1;
    @(negedge clk);
    bus.LOAD = 1'b0;
    check({v.name, "_rdy_low"}, int'(bus.TX_RDY), 0);
    check({v.name, "_tx_pre"}, int'(bus.TX), 1);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_bit%0d", v.name, i), int'(bus.TX), int'(v.exp_bits[i]));
      for (int j = 0; j <= v.baud_k; j++) begin
        if (j == 0 && i == 3 && v.busy_load) begin
          bus.OUT_PORT = 8'h55;
          bus.LOAD     = 1'b1;
        end
        if (j == 0 && i == 2 && v.flip_cfg) begin
          bus.EIGHT = ~bus.EIGHT;
          bus.PEN   = ~bus.PEN;
        end
        @(negedge clk);
        bus.LOAD = 1'b0;
      end
    end
    // DONE cycle: still busy, line idle
    check({v.name, "_done_rdy"}, int'(bus.TX_RDY), 0);
    check({v.name, "_done_tx"}, int'(bus.TX), 1);
    if (v.done_load) begin
      bus.OUT_PORT = 8'h55;
      bus.LOAD     = 1'b1;
    end
    @(negedge clk);
    bus.LOAD = 1'b0;
    check({v.name, "_rdy_back"}, int'(bus.TX_RDY), 1);
    if (v.done_load) begin
      @(negedge clk);
      check({v.name, "_dload_rdy"}, int'(bus.TX_RDY), 1);
      check({v.name, "_dload_tx"}, int'(bus.TX), 1);
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{"a5_8n",    3, 1'b1, 1'b0, 1'b0, 8'hA5, 11'b11101001010, 0, 0, 0};
    vecs[1] = '{"03_8e",    2, 1'b1, 1'b1, 1'b0, 8'h03, 11'b10000000110, 0, 0, 0};
    vecs[2] = '{"03_8o",    2, 1'b1, 1'b1, 1'b1, 8'h03, 11'b11000000110, 0, 0, 0};
    vecs[3] = '{"ff_7e",    1, 1'b0, 1'b1, 1'b0, 8'hFF, 11'b11111111110, 0, 0, 0};
    vecs[4] = '{"a5_busy",  1, 1'b1, 1'b0, 1'b0, 8'hA5, 11'b11101001010, 1, 1, 0};
    vecs[5] = '{"80_7n",    1, 1'b0, 1'b0, 1'b0, 8'h80, 11'b11100000000, 0, 0, 0};
    vecs[6] = '{"5a_8o_k0", 0, 1'b1, 1'b1, 1'b1, 8'h5A, 11'b11010110100, 0, 0, 1};
    vecs[7] = '{"41_7o_k0", 0, 1'b0, 1'b1, 1'b1, 8'h41, 11'b11110000010, 0, 0, 0};

    reset        = 1'b1;
    bus.BAUD_K   = '0;
    bus.EIGHT    = 1'b0;
    bus.PEN      = 1'b0;
    bus.OHEL     = 1'b0;
    bus.LOAD     = 1'b0;
    bus.OUT_PORT = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(bus.TX), 1);
    check("reset_rdy", int'(bus.TX_RDY), 1);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) send(vecs[k]);

    // Asynchronous reset during the start bit
    wait_rdy();
    bus.BAUD_K   = 19'd3;
    bus.EIGHT    = 1'b1;
    bus.PEN      = 1'b0;
    bus.OUT_PORT = 8'h00;
    bus.LOAD     = 1'b1;
    @(negedge clk);
    bus.LOAD = 1'b0;
    @(negedge clk);
    check("rst_pre_tx", int'(bus.TX), 0);
    #1 reset = 1'b1;
    #1;
    check("rst_async_tx", int'(bus.TX), 1);
    check("rst_async_rdy", int'(bus.TX_RDY), 1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.TX !== 1'b1 || bus.TX_RDY !== 1'b1) bad++;
    end
    check("rst_no_resume", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
